// File: rtl/sr_pulse_gen.sv
// Pushbutton front-end for the SR/JK latches: synchronizes and debounces two raw
// buttons, then emits mutually exclusive fixed-width S/R pulses with a guard gap.
module sr_pulse_gen #(
  parameter int DB_CNT    = 4,
  parameter int PULSE_LEN = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_set,
  input  logic btn_rst,
  output logic s_out,
  output logic r_out,
  output logic busy,
  output logic conflict,
  output logic state_q
);

  localparam int CW = $clog2(DB_CNT);
  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CNT - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(PULSE_LEN - 1);

  typedef enum logic [1:0] {IDLE, SPULSE, RPULSE, GAP} state_t;

  // Channel vectors: bit 0 is the set button, bit 1 the reset button.
  logic [1:0]         sync1, sync2, db, db_prev, req, pend, pend_n, served;
  logic [1:0][CW-1:0] db_cnt;
  logic [PW-1:0]      pcnt, pcnt_n;
  state_t             state, state_n;
  logic               conflict_n, state_q_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_rst, btn_set};
      sync2 <= sync1;
    end
  end

  // The level only moves after DB_CNT consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db     <= '0;
      db_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_prev <= '0;
      req     <= '0;
    end else begin
      db_prev <= db;
      req     <= db & ~db_prev;
    end
  end

  always_comb begin
    state_n    = state;
    pcnt_n     = pcnt;
    pend_n     = pend;
    conflict_n = 1'b0;
    state_q_n  = state_q;
    served     = '0;
    case (state)
      IDLE: begin
        pcnt_n = '0;
        if (req[0] && req[1]) begin
          conflict_n = 1'b1;
        end else if (req[0]) begin
          state_n = SPULSE;
        end else if (req[1]) begin
          state_n = RPULSE;
        end
      end
      SPULSE, RPULSE: begin
        pend_n = pend | req;
        if (pcnt == P_LAST) begin
          state_n   = GAP;
          pcnt_n    = '0;
          state_q_n = (state == SPULSE);
        end else begin
          pcnt_n = pcnt + PW'(1);
        end
      end
      GAP: begin
        // A request landing in the gap cycle itself is served with the pending ones.
        served = pend | req;
        pend_n = '0;
        if (served[0] && served[1]) begin
          conflict_n = 1'b1;
          state_n    = IDLE;
        end else if (served[0]) begin
          state_n = SPULSE;
        end else if (served[1]) begin
          state_n = RPULSE;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they switch cleanly on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pcnt     <= '0;
      pend     <= '0;
      s_out    <= 1'b0;
      r_out    <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
      state_q  <= 1'b0;
    end else begin
      state    <= state_n;
      pcnt     <= pcnt_n;
      pend     <= pend_n;
      s_out    <= (state_n == SPULSE);
      r_out    <= (state_n == RPULSE);
      busy     <= (state_n != IDLE);
      conflict <= conflict_n;
      state_q  <= state_q_n;
    end
  end

endmodule
